// File: rtl/seg7_multi_counter.sv
// N-digit BCD up/down counter with programmable prescaler, driving a multiplexed
// common-cathode 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_multi_counter #(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE_W    = 24,
    parameter int DEFAULT_COUNT = 10_000_000,
    parameter int SCAN_DIV      = 10_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clear,
    input  logic                    up_down,
    input  logic [7:0]              cmp_in,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_value,
    output logic                    tick,
    output logic                    wrap
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRESCALE_W-1:0]   presc;
    logic [PRESCALE_W-1:0]   compare;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [4*NUM_DIGITS-1:0] bcd_next;
    logic                    roll_wrap;
    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [3:0]              cur_digit;
    logic [6:0]              seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        if (cmp_in == 8'd0) compare = PRESCALE_W'(DEFAULT_COUNT);
        else                compare = PRESCALE_W'({cmp_in, 10'b0});
    end

    // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
    always_comb begin
        bcd_next  = bcd_q;
        roll_wrap = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (roll_wrap) begin
                if (up_down) begin
                    if (bcd_q[4*i +: 4] >= 4'd9) begin
                        bcd_next[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_next[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        roll_wrap          = 1'b0;
                    end
                end else begin
                    if (bcd_q[4*i +: 4] == 4'd0) begin
                        bcd_next[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_next[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                        roll_wrap          = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc <= '0;
            bcd_q <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (en && (presc >= compare)) begin
            presc <= '0;
            bcd_q <= bcd_next;
            tick  <= 1'b1;
            wrap  <= roll_wrap;
        end else begin
            if (en) presc <= presc + 1'b1;
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (scan_idx == IDX_W'(NUM_DIGITS - 1)) scan_idx <= '0;
            else                                    scan_idx <= scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) cur_digit = bcd_q[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank the selected digit when it and every digit above it are zero.
    logic upper_nonzero;
    always_comb begin
        upper_nonzero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= scan_idx) && (bcd_q[4*i +: 4] != 4'd0)) upper_nonzero = 1'b1;
        end
        seg_next = seg_decode(cur_digit);
        if ((scan_idx != '0) && !upper_nonzero) seg_next = 7'h00;
    end
`else
    always_comb begin
        seg_next = seg_decode(cur_digit);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            segments  <= 7'h00;
            dp        <= 1'b0;
            digit_sel <= '0;
        end else begin
            segments  <= seg_next;
            dp        <= (scan_idx == '0) && (presc < (compare >> 1));
            digit_sel <= NUM_DIGITS'(1) << scan_idx;
        end
    end

    assign bcd_value = bcd_q;

endmodule

// File: tb/tb_seg7_multi_counter.sv
// Scoreboard bench for seg7_multi_counter: integer-valued reference model predicts
// ticks, counter value and the scanned display image cycle by cycle.
module tb_seg7_multi_counter;
    localparam int ND   = 2;
    localparam int PW   = 24;
    localparam int DC   = 9;
    localparam int SD   = 4;
    localparam int MAXC = 30000;

    logic          clk = 1'b0;
    logic          reset, en, clear, up_down;
    logic [7:0]    cmp_in;
    logic [6:0]    segments;
    logic          dp, tick, wrap;
    logic [ND-1:0] digit_sel;
    logic [4*ND-1:0] bcd_value;

    seg7_multi_counter #(.NUM_DIGITS(ND), .PRESCALE_W(PW), .DEFAULT_COUNT(DC), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .up_down(up_down), .cmp_in(cmp_in),
        .segments(segments), .dp(dp), .digit_sel(digit_sel), .bcd_value(bcd_value),
        .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {int cyc; int val; bit wrap;} exp_t;
    exp_t sb[$];

    logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    // Per-edge model record, indexed by edge number.
    int pre_val [MAXC];
    int post_val[MAXC];
    int pre_presc[MAXC];
    int cmp_at  [MAXC];
    int idx_at  [MAXC];
    bit rst_at  [MAXC];

    int m_presc = 0;
    int m_val = 0;
    int j0 = 1;

    function automatic int pow10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int to_bcd(int v);
        int r = 0;
        for (int i = 0; i < ND; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int compare_of(logic [7:0] c);
        return (c == 8'd0) ? DC : int'(c) * 1024;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Predict the effect of the next clock edge given the inputs now applied.
    task automatic step();
        int e, cmpv, nv;
        e = cyc + 1;
        if (e >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d exceeded %0d", e, MAXC);
            $fatal(1);
        end
        cmpv         = compare_of(cmp_in);
        pre_val[e]   = m_val;
        pre_presc[e] = m_presc;
        cmp_at[e]    = cmpv;
        rst_at[e]    = reset;
        if (reset) begin
            m_presc = 0;
            m_val   = 0;
            j0      = e + 1;
            idx_at[e] = 0;
        end else begin
            idx_at[e] = ((e - j0) / SD) % ND;
            if (clear) begin
                m_presc = 0;
                m_val   = 0;
            end else if (en) begin
                if (m_presc >= cmpv) begin
                    m_presc = 0;
                    if (up_down) nv = (m_val + 1) % pow10(ND);
                    else         nv = (m_val + pow10(ND) - 1) % pow10(ND);
                    sb.push_back('{cyc: e, val: nv, wrap: up_down ? (nv == 0) : (m_val == 0)});
                    m_val = nv;
                end else begin
                    m_presc++;
                end
            end
        end
        post_val[e] = m_val;
    endtask

    task automatic drive(bit r, bit e_, bit c, bit ud, logic [7:0] cm);
        @(posedge clk);
        #1;
        reset = r; en = e_; clear = c; up_down = ud; cmp_in = cm;
        step();
    endtask

    // Monitor: tick events are popped from the scoreboard; display image checked every cycle.
    always @(negedge clk) begin
        int c, idx, dig;
        logic [6:0] eseg;
        c = cyc;
        if (c >= 1 && c < MAXC) begin
            while (sb.size() > 0 && sb[0].cyc < c) begin
                checks++;
                errors++;
                $display("FAIL tick_missing cyc=%0d got=none exp=tick@%0d", c, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == c) begin
                chk("tick", {31'b0, tick}, 32'd1);
                chk("tick_bcd", {24'b0, bcd_value}, to_bcd(sb[0].val));
                chk("tick_wrap", {31'b0, wrap}, {31'b0, sb[0].wrap});
                void'(sb.pop_front());
            end else begin
                chk("no_tick", {31'b0, tick}, 32'd0);
                chk("no_wrap", {31'b0, wrap}, 32'd0);
            end
            chk("bcd_value", {24'b0, bcd_value}, to_bcd(post_val[c]));
            if (rst_at[c]) begin
                chk("rst_segments", {25'b0, segments}, 32'd0);
                chk("rst_dp", {31'b0, dp}, 32'd0);
                chk("rst_digit_sel", {30'b0, digit_sel}, 32'd0);
            end else begin
                idx  = idx_at[c];
                dig  = (to_bcd(pre_val[c]) >> (4 * idx)) & 15;
                eseg = dec[dig];
`ifdef LEADING_ZERO_BLANK_EN
                if (idx > 0 && pre_val[c] < pow10(idx)) eseg = 7'h00;
`endif
                chk("digit_sel", {30'b0, digit_sel}, 32'd1 << idx);
                chk("segments", {25'b0, segments}, {25'b0, eseg});
                chk("dp", {31'b0, dp}, {31'b0, (idx == 0) && (pre_presc[c] < (cmp_at[c] >> 1))});
            end
        end
    end

    initial begin
        bit ud;
        logic [7:0] cm;
        reset = 1'b1; en = 1'b1; clear = 1'b0; up_down = 1'b1; cmp_in = 8'h00;
        step();
        repeat (2) drive(1, 1, 0, 1, 8'h00);

        // Up count through the full range: 100 ticks end in 99 -> 00 with wrap.
        repeat (1010) drive(0, 1, 0, 1, 8'h00);

        // Down from reset: 00 -> 99 with wrap, then 98.
        repeat (3) drive(1, 1, 0, 0, 8'h00);
        repeat (25) drive(0, 1, 0, 0, 8'h00);

        // Count up to 42, then freeze for 50 cycles while the display keeps scanning.
        repeat (3) drive(1, 1, 0, 1, 8'h00);
        for (int k = 0; k < 600 && m_val != 42; k++) drive(0, 1, 0, 1, 8'h00);
        if (m_val != 42) begin
            checks++; errors++;
            $display("FAIL reach_42 got=%0d exp=42", m_val);
        end
        repeat (50) drive(0, 0, 0, 1, 8'h00);

        // Clear asserted on a rollover cycle.
        for (int k = 0; k < 20 && m_presc < DC; k++) drive(0, 1, 0, 1, 8'h00);
        if (m_presc < DC) begin
            checks++; errors++;
            $display("FAIL reach_rollover got=%0d exp=%0d", m_presc, DC);
        end
        drive(0, 1, 1, 1, 8'h00);
        repeat (15) drive(0, 1, 0, 1, 8'h00);

        // Compare lowered mid-count, then dropped below the current prescaler value.
        for (int k = 0; k < 3000 && m_presc != 500; k++) drive(0, 1, 0, 1, 8'h02);
        if (m_presc != 500) begin
            checks++; errors++;
            $display("FAIL reach_500 got=%0d exp=500", m_presc);
        end
        repeat (2200) drive(0, 1, 0, 1, 8'h01);
        for (int k = 0; k < 1100 && m_presc != 700; k++) drive(0, 1, 0, 1, 8'h01);
        if (m_presc != 700) begin
            checks++; errors++;
            $display("FAIL reach_700 got=%0d exp=700", m_presc);
        end
        repeat (30) drive(0, 1, 0, 1, 8'h00);

        // Randomized traffic.
        ud = 1'b1;
        cm = 8'h00;
        for (int k = 0; k < 3000; k++) begin
            if (k % 250 == 0) cm = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
            if ($urandom_range(0, 31) == 0) ud = ~ud;
            drive($urandom_range(0, 599) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 79) == 0, ud, cm);
        end

        // Low values for the leading-digit display path.
        repeat (3) drive(1, 1, 0, 1, 8'h00);
        for (int k = 0; k < 200 && m_val != 7; k++) drive(0, 1, 0, 1, 8'h00);
        repeat (20) drive(0, 0, 0, 1, 8'h00);
        repeat (3) drive(1, 0, 0, 1, 8'h00);
        repeat (20) drive(0, 0, 0, 1, 8'h00);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
